data_mem_arbiter: RTL and testbench

//  Shares the single-port data memory between the MEM-stage pipeline port and the debug unit.

---
 rtl/data_mem_arbiter.sv | 114 +++++++++++
 tb/tb_data_mem_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data memory between CPU, debug unit and a clear sequencer.
// Priority CLEAR > CPU > DEBUG, with a wait counter that forces a debug grant.
module data_mem_arbiter #(
  parameter int ADDR_SIZE    = 5,
  parameter int SLOT_SIZE    = 32,
  parameter int DBG_MAX_WAIT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_cpu_req,
  input  logic                 i_cpu_wr,
  input  logic [ADDR_SIZE-1:0] i_cpu_addr,
  input  logic [SLOT_SIZE-1:0] i_cpu_data,
  output logic [SLOT_SIZE-1:0] o_cpu_data,
  output logic                 o_cpu_stall,
  input  logic                 i_dbg_req,
  input  logic                 i_dbg_wr,
  input  logic [ADDR_SIZE-1:0] i_dbg_addr,
  input  logic [SLOT_SIZE-1:0] i_dbg_data,
  output logic                 o_dbg_ack,
  output logic [SLOT_SIZE-1:0] o_dbg_data,
  input  logic                 i_clear_start,
  output logic                 o_clear_busy,
  output logic                 o_clear_done,
  output logic                 o_mem_wr,
  output logic [ADDR_SIZE-1:0] o_mem_addr,
  output logic [SLOT_SIZE-1:0] o_mem_data,
  input  logic [SLOT_SIZE-1:0] i_mem_data
);
  localparam int WW = $clog2(DBG_MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(DBG_MAX_WAIT);
  localparam logic [ADDR_SIZE-1:0] CLR_LAST = {ADDR_SIZE{1'b1}};
  localparam logic [1:0] IDLE = 2'd0, CLEAR = 2'd1, DBG_RELEASE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_SIZE-1:0] clr_cnt_q, clr_cnt_d;
  logic                 dbg_ack_q, dbg_ack_d;
  logic [SLOT_SIZE-1:0] dbg_data_q, dbg_data_d;
  logic                 clear_busy_q, clear_busy_d;
  logic                 clear_done_q, clear_done_d;
  logic                 clear_pend_q, clear_pend_d;
  logic                 in_idle, in_clr, dbg_pending, force_dbg, cpu_grant, dbg_grant, start;
  logic                 mem_wr;

  assign in_idle     = state_q == IDLE;
  assign in_clr      = state_q == CLEAR;
  assign dbg_pending = in_idle && i_dbg_req;
  assign force_dbg   = dbg_pending && wait_cnt_q == WMAX;
  assign cpu_grant   = !in_clr && i_cpu_req && !force_dbg;
  assign dbg_grant   = dbg_pending && !cpu_grant;
  assign start       = i_clear_start || clear_pend_q;

  assign mem_wr      = in_clr ? 1'b1 : cpu_grant ? i_cpu_wr : dbg_grant && i_dbg_wr;
  assign o_mem_wr    = i_reset && mem_wr;
  assign o_mem_addr  = in_clr ? clr_cnt_q : dbg_grant ? i_dbg_addr : i_cpu_addr;
  assign o_mem_data  = in_clr ? '0 : dbg_grant ? i_dbg_data : i_cpu_data;
  assign o_cpu_data  = i_mem_data;
  assign o_cpu_stall = i_reset && i_cpu_req && !cpu_grant;
  assign o_dbg_ack    = dbg_ack_q;
  assign o_dbg_data   = dbg_data_q;
  assign o_clear_busy = clear_busy_q;
  assign o_clear_done = clear_done_q;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    clr_cnt_d    = clr_cnt_q;
    dbg_ack_d    = 1'b0;
    dbg_data_d   = dbg_grant ? i_mem_data : dbg_data_q;
    clear_busy_d = clear_busy_q;
    clear_done_d = 1'b0;
    clear_pend_d = clear_pend_q;
    if (in_idle) begin
      dbg_ack_d    = dbg_grant;
      wait_cnt_d   = (!i_dbg_req || dbg_grant) ? '0 : (wait_cnt_q == WMAX ? WMAX : wait_cnt_q + 1'b1);
      clear_pend_d = 1'b0;
      state_d      = start ? CLEAR : dbg_grant ? DBG_RELEASE : IDLE;
      clr_cnt_d    = start ? '0 : clr_cnt_q;
      clear_busy_d = start;
    end else if (in_clr) begin
      clr_cnt_d    = clr_cnt_q + 1'b1;
      state_d      = clr_cnt_q == CLR_LAST ? IDLE : CLEAR;
      clear_busy_d = clr_cnt_q != CLR_LAST;
      clear_done_d = clr_cnt_q == CLR_LAST;
    end else begin
      // a clear requested while waiting for debug release is replayed from IDLE
      state_d      = i_dbg_req ? DBG_RELEASE : IDLE;
      clear_pend_d = clear_pend_q || i_clear_start;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      clr_cnt_q    <= '0;
      dbg_ack_q    <= 1'b0;
      dbg_data_q   <= '0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
      clear_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      clr_cnt_q    <= clr_cnt_d;
      dbg_ack_q    <= dbg_ack_d;
      dbg_data_q   <= dbg_data_d;
      clear_busy_q <= clear_busy_d;
      clear_done_q <= clear_done_d;
      clear_pend_q <= clear_pend_d;
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed bench for data_mem_arbiter with a behavioural async-read memory.
module tb_data_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_wr, dbg_req, dbg_wr, clear_start;
  logic [4:0]  cpu_addr, dbg_addr;
  logic [31:0] cpu_data, dbg_data;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        cpu_stall, dbg_ack, clear_busy, clear_done;
  logic        mem_wr;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [32];
  int          tests = 0;
  int          fails = 0;
  int          cnt;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  data_mem_arbiter dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_wr(cpu_wr), .i_cpu_addr(cpu_addr), .i_cpu_data(cpu_data),
    .o_cpu_data(cpu_rdata), .o_cpu_stall(cpu_stall),
    .i_dbg_req(dbg_req), .i_dbg_wr(dbg_wr), .i_dbg_addr(dbg_addr), .i_dbg_data(dbg_data),
    .o_dbg_ack(dbg_ack), .o_dbg_data(dbg_rdata),
    .i_clear_start(clear_start), .o_clear_busy(clear_busy), .o_clear_done(clear_done),
    .o_mem_wr(mem_wr), .o_mem_addr(mem_addr), .o_mem_data(mem_wdata), .i_mem_data(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill();
    for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 | i;
  endtask

  initial begin
    fill();
    rst_n = 1'b0; cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 5'd1; cpu_data = 32'h1111_1111;
    dbg_req = 1'b0; dbg_wr = 1'b0; dbg_addr = '0; dbg_data = '0; clear_start = 1'b0;
    #1;
    tick(); tick();
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_ack", dbg_ack, 0);
    chk("rst_dbg_data", dbg_rdata, 0);
    chk("rst_busy", clear_busy, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_no_write", mem[1], 32'hA500_0001);
    rst_n = 1'b1;
    // CPU write then zero-latency read
    cpu_addr = 5'd3; cpu_data = 32'hDEAD_BEEF; #1;
    chk("cpu_wr_en", mem_wr, 1);
    chk("cpu_wr_addr", mem_addr, 3);
    chk("cpu_wr_stall", cpu_stall, 0);
    tick();
    cpu_wr = 1'b0; #1;
    chk("cpu_rd_data", cpu_rdata, 32'hDEAD_BEEF);
    chk("cpu_rd_stall", cpu_stall, 0);
    chk("cpu_rd_wr", mem_wr, 0);
    tick();
    cpu_req = 1'b0;
    // debug read with CPU idle
    dbg_req = 1'b1; dbg_addr = 5'd3; #1;
    chk("dbg_addr", mem_addr, 3);
    chk("dbg_no_ack_yet", dbg_ack, 0);
    tick();
    chk("dbg_ack", dbg_ack, 1);
    chk("dbg_data", dbg_rdata, 32'hDEAD_BEEF);
    dbg_req = 1'b0;
    tick();
    chk("dbg_ack_pulse", dbg_ack, 0);
    // starvation: CPU every cycle, debug forced after 8 denials
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'd5;
    dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd7; dbg_data = 32'h1234_5678;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("deny_stall_%0d", i), cpu_stall, 0);
      chk($sformatf("deny_addr_%0d", i), mem_addr, 5);
      tick();
      chk($sformatf("deny_ack_%0d", i), dbg_ack, 0);
    end
    #1;
    chk("force_stall", cpu_stall, 1);
    chk("force_wr", mem_wr, 1);
    chk("force_addr", mem_addr, 7);
    tick();
    chk("force_ack", dbg_ack, 1);
    chk("force_mem", mem[7], 32'h1234_5678);
    chk("release_cpu_served", cpu_stall, 0);
    dbg_req = 1'b0; cpu_req = 1'b0;
    tick();
    // full clear with CPU stalled throughout
    fill();
    clear_start = 1'b1; #1;
    tick();
    clear_start = 1'b0; cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 5'd2; cpu_data = 32'hFFFF_FFFF;
    cnt = 0;
    for (int k = 0; k < 32; k++) begin
      clear_start = (k == 5); #1;
      if (!(clear_busy && mem_wr && mem_addr == 5'(k) && mem_wdata == 0 && cpu_stall && !clear_done)) cnt++;
      tick();
    end
    clear_start = 1'b0;
    chk("clr_cycles_bad", cnt, 0);
    chk("clr_done", clear_done, 1);
    chk("clr_busy_end", clear_busy, 0);
    cpu_req = 1'b0; #1;
    tick();
    chk("clr_done_pulse", clear_done, 0);
    cnt = 0;
    for (int i = 0; i < 32; i++) if (mem[i] != 0) cnt++;
    chk("clr_nonzero_words", cnt, 0);
    // reset in the middle of a clear
    fill();
    clear_start = 1'b1; #1;
    tick();
    clear_start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst_n = 1'b0; #1;
    chk("midrst_mem_wr", mem_wr, 0);
    tick();
    rst_n = 1'b1;
    chk("midrst_busy", clear_busy, 0);
    cnt = 0;
    for (int k = 0; k < 35; k++) begin
      tick();
      if (clear_done) cnt++;
    end
    chk("midrst_done_pulses", cnt, 0);
    cnt = 0;
    for (int i = 0; i < 32; i++) if (mem[i] != (i < 10 ? 32'h0 : (32'hA500_0000 | i))) cnt++;
    chk("midrst_partial_words", cnt, 0);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'd20; #1;
    chk("midrst_cpu_rd", cpu_rdata, 32'hA500_0014);
    chk("midrst_cpu_stall", cpu_stall, 0);
    cpu_req = 1'b0;
    // held debug request acks only once
    dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 5'd12; #1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (dbg_ack) cnt++;
    end
    chk("held_ack_count", cnt, 1);
    dbg_req = 1'b0;
    tick();
    dbg_req = 1'b1; dbg_addr = 5'd15; #1;
    tick();
    chk("reraise_ack", dbg_ack, 1);
    chk("reraise_data", dbg_rdata, 32'hA500_000F);
    dbg_req = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
